imem_loader: RTL and testbench

Boot-time loader that fills the byte-addressed 2 KiB instruction memory from an 8-bit byte stream, such as a UART receiver, before the core starts fetching. It parses a framed image and issues one byte write per payload byte into the memory's write port:
- 16-bit little-endian length, then the payload bytes, then an 8-bit additive checksum.

It holds the core in reset until a complete, checksum-valid image has been written. It is the write-side counterpart of the fetch path, which reads four consecutive bytes little-endian as one instruction.

---
 rtl/imem_loader_pkg.sv | 32 +++
 rtl/imem_loader_if.sv | 31 +++
 rtl/imem_ram.sv | 33 +++
 rtl/imem_loader.sv | 148 ++++++++++++++
 tb/tb_imem_loader.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

  localparam int ADDR_W    = 11;
  localparam int MEM_BYTES = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } state_e;

  typedef logic [1:0] err_t;

  localparam err_t ERR_NONE = 2'b00;
  localparam err_t ERR_LEN  = 2'b01;
  localparam err_t ERR_CSUM = 2'b10;

  function automatic logic is_rx_state(input state_e s);
    return (s == LEN_LO) || (s == LEN_HI) ||
           (s == DATA)   || (s == CSUM);
  endfunction

  function automatic logic is_idle_state(input state_e s);
    return (s == IDLE) || (s == DONE) || (s == ERROR);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in and byte write port out of the loader.
interface imem_loader_if #(
  parameter int AW = 11
);

  logic          i_rx_valid;
  logic [7:0]    i_rx_data;
  logic          o_rx_ready;
  logic          o_wr_en;
  logic [AW-1:0] o_wr_addr;
  logic [7:0]    o_wr_data;

  modport master (
    input  i_rx_valid,
    input  i_rx_data,
    output o_rx_ready,
    output o_wr_en,
    output o_wr_addr,
    output o_wr_data
  );

  modport slave (
    output i_rx_valid,
    output i_rx_data,
    input  o_rx_ready,
    input  o_wr_en,
    input  o_wr_addr,
    input  o_wr_data
  );

endinterface

// File: rtl/imem_ram.sv
// Byte-writable instruction memory with a combinational
// 32-bit little-endian read of bytes a..a+3.
module imem_ram #(
  parameter int ADDR_W = 11
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [31:0]       o_rdata
);

  logic [7:0] mem_q [2**ADDR_W];

  logic [ADDR_W-1:0] a1;
  logic [ADDR_W-1:0] a2;
  logic [ADDR_W-1:0] a3;

  assign a1 = i_raddr + ADDR_W'(1);
  assign a2 = i_raddr + ADDR_W'(2);
  assign a3 = i_raddr + ADDR_W'(3);

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = {mem_q[a3], mem_q[a2],
                    mem_q[a1], mem_q[i_raddr]};

endmodule

// File: rtl/imem_loader.sv
// Parses [len16 LE][payload][sum8] from a byte stream into
// instruction memory and holds the core in reset until verified.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 11,
  parameter int MEM_BYTES = 2 ** ADDR_W
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  imem_loader_if.master   bus,
  output logic            o_busy,
  output logic            o_done,
  output logic [1:0]      o_err,
  output logic            o_cpu_rst,
  output logic [ADDR_W:0] o_byte_cnt
);

  state_e state_q;
  state_e state_d;

  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   len_d;
  logic [7:0]        sum_q;
  logic [7:0]        sum_d;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   cnt_d;
  err_t              err_q;
  err_t              err_d;

  logic              wr_en_q;
  logic              wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [7:0]        wr_data_q;
  logic [7:0]        wr_data_d;

  logic              rx_ready;
  logic              accept;
  logic              load_req;
  logic [15:0]       len_full;
  logic [ADDR_W:0]   cnt_inc;

  assign rx_ready = is_rx_state(state_q);
  assign accept   = bus.i_rx_valid && rx_ready;
  assign load_req = i_start && is_idle_state(state_q);
  assign len_full = {bus.i_rx_data, len_q[7:0]};
  assign cnt_inc  = cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (load_req) begin
      state_d = LEN_LO;
      cnt_d   = '0;
      sum_d   = '0;
      err_d   = ERR_NONE;
    end

    unique case (state_q)
      LEN_LO: begin
        if (accept) begin
          len_d   = {{(ADDR_W-7){1'b0}}, bus.i_rx_data};
          state_d = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept) begin
          len_d = len_full[ADDR_W:0];
          if (len_full > 16'(MEM_BYTES)) begin
            state_d = ERROR;
            err_d   = ERR_LEN;
          end else if (len_full == 16'd0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q[ADDR_W-1:0];
          wr_data_d = bus.i_rx_data;
          sum_d     = sum_q + bus.i_rx_data;
          cnt_d     = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (accept) begin
          if (bus.i_rx_data == sum_q) begin
            state_d = DONE;
          end else begin
            state_d = ERROR;
            err_d   = ERR_CSUM;
          end
        end
      end
      default: ;
    endcase
  end

  // Synchronous reset also squashes a write registered this cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      err_q     <= ERR_NONE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.o_rx_ready = rx_ready;
  assign bus.o_wr_en    = wr_en_q;
  assign bus.o_wr_addr  = wr_addr_q;
  assign bus.o_wr_data  = wr_data_q;

  assign o_busy     = rx_ready;
  assign o_done     = (state_q == DONE);
  assign o_cpu_rst  = (state_q != DONE);
  assign o_err      = err_q;
  assign o_byte_cnt = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized loader bench with a frame-level reference model.
module tb_imem_loader;

  localparam int AW = 11;
  localparam int NB = 2048;

  logic          clk;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic [1:0]    err;
  logic          cpu_rst;
  logic [AW:0]   byte_cnt;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;

  imem_loader_if #(.AW(AW)) bus ();

  imem_loader #(.ADDR_W(AW)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .bus        (bus.master),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err),
    .o_cpu_rst  (cpu_rst),
    .o_byte_cnt (byte_cnt)
  );

  imem_ram #(.ADDR_W(AW)) ram (
    .i_clk   (clk),
    .i_we    (bus.o_wr_en),
    .i_waddr (bus.o_wr_addr),
    .i_wdata (bus.o_wr_data),
    .i_raddr (rd_addr),
    .o_rdata (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  wr_t        log_q[$];
  logic [7:0] mem_m [NB];
  bit         mem_v [NB];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.o_wr_en === 1'b1) begin
      log_q.push_back('{a: bus.o_wr_addr, d: bus.o_wr_data});
      chk("cnt_at_write", byte_cnt, 64'(bus.o_wr_addr) + 1);
    end
  end

  task automatic push(input logic [7:0] b, input bit rnd,
                      inout bit ok);
    int n;
    bit acc;
    if (rnd) begin
      while ($urandom_range(0, 2) == 0) begin
        bus.i_rx_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = b;
    // Busy-state i_start pulses must be ignored.
    start = rnd && ($urandom_range(0, 7) == 0);
    n = 0;
    do begin
      acc = bus.o_rx_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 50);
    start = 1'b0;
    if (!acc) begin
      chk("rx_timeout", 64'(acc), 64'd1);
      ok = 1'b0;
    end
  endtask

  task automatic check_mem(input string tag);
    int bad;
    bad = 0;
    for (int a = 0; a < NB; a++) begin
      if (mem_v[a]) begin
        rd_addr = AW'(a);
        #1;
        if (rd_data[7:0] !== mem_m[a]) bad++;
      end
    end
    @(posedge clk); #1;
    chk({tag, ".mem"}, 64'(bad), 64'd0);
  endtask

  task automatic run_load(input string tag, input logic [7:0] fr[$],
                          input bit rnd);
    int len, nacc, nwr, bad;
    logic [7:0] s;
    logic [1:0] ee;
    bit ok;
    len = int'({fr[1], fr[0]});
    if (len > NB) begin
      ee = 2'b01; nacc = 2; nwr = 0;
    end else begin
      s = 8'h00;
      for (int i = 0; i < len; i++) s += fr[2+i];
      ee = (fr[2+len] == s) ? 2'b00 : 2'b10;
      nacc = len + 3;
      nwr = len;
    end
    log_q.delete();
    start = 1'b1;
    if (rnd) begin
      bus.i_rx_valid = 1'b1;
      bus.i_rx_data  = fr[0];
    end
    @(posedge clk); #1;
    start = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < nacc && ok; i++) push(fr[i], rnd && i > 0, ok);
    bus.i_rx_valid = 1'b0;
    for (int i = 0; i < nwr; i++) begin
      mem_m[i] = fr[2+i];
      mem_v[i] = 1'b1;
    end
    chk({tag, ".done"}, 64'(done), 64'(ee == 2'b00));
    chk({tag, ".err"}, 64'(err), 64'(ee));
    chk({tag, ".cpu_rst"}, 64'(cpu_rst), 64'(ee != 2'b00));
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    chk({tag, ".cnt"}, 64'(byte_cnt), 64'(nwr));
    bad = 0;
    if (log_q.size() != nwr) bad = 1;
    else
      foreach (log_q[i])
        if (log_q[i].a != AW'(i) || log_q[i].d != fr[2+i]) bad++;
    chk({tag, ".writes"}, 64'(bad), 64'd0);
    check_mem(tag);
  endtask

  function automatic void rand_frame(output logic [7:0] fr[$],
                                     input int len, input bit corrupt);
    logic [7:0] s;
    logic [7:0] b;
    fr.delete();
    fr.push_back(8'(len));
    fr.push_back(8'(len >> 8));
    s = 8'h00;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      fr.push_back(b);
      s += b;
    end
    if (corrupt) s += 8'($urandom_range(1, 255));
    fr.push_back(s);
  endfunction

  logic [7:0] fr[$];

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data = 8'h00;
    rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.rx_ready", 64'(bus.o_rx_ready), 64'd0);
    chk("rst.wr_en", 64'(bus.o_wr_en), 64'd0);
    chk("rst.wr_addr", 64'(bus.o_wr_addr), 64'd0);
    chk("rst.wr_data", 64'(bus.o_wr_data), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.err", 64'(err), 64'd0);
    chk("rst.cpu_rst", 64'(cpu_rst), 64'd1);
    chk("rst.cnt", 64'(byte_cnt), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    fr = {8'h04, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB8};
    run_load("load4", fr, 1'b0);
    rd_addr = '0;
    #1;
    chk("load4.word0", 64'(rd_data), 64'h00A00513);
    @(posedge clk); #1;

    fr = {8'h04, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB9};
    run_load("csum_err", fr, 1'b0);

    fr = {8'h01, 8'h08};
    run_load("len_ovf", fr, 1'b0);
    fr = {8'h04, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB8};
    run_load("after_ovf", fr, 1'b0);

    fr.delete();
    fr.push_back(8'h00);
    fr.push_back(8'h08);
    for (int i = 0; i < NB; i++) fr.push_back(8'(i));
    fr.push_back(8'h00);
    run_load("full", fr, 1'b0);
    chk("full.last_addr", 64'(log_q[log_q.size()-1].a), 64'd2047);
    chk("full.last_data", 64'(log_q[log_q.size()-1].d), 64'hFF);

    for (int k = 0; k < 6; k++) begin
      rand_frame(fr, $urandom_range(1, 40), $urandom_range(0, 2) == 0);
      run_load($sformatf("rnd%0d", k), fr, 1'b1);
    end

    fr = {8'h00, 8'h00, 8'h00};
    run_load("len0", fr, 1'b1);

    begin
      bit ok;
      ok = 1'b1;
      log_q.delete();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      fr = {8'h04, 8'h00, 8'h5A, 8'hC3};
      foreach (fr[i]) if (ok) push(fr[i], 1'b0, ok);
      bus.i_rx_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst.rx_ready", 64'(bus.o_rx_ready), 64'd0);
      chk("midrst.wr_en", 64'(bus.o_wr_en), 64'd0);
      chk("midrst.wr_addr", 64'(bus.o_wr_addr), 64'd0);
      chk("midrst.wr_data", 64'(bus.o_wr_data), 64'd0);
      chk("midrst.busy", 64'(busy), 64'd0);
      chk("midrst.done", 64'(done), 64'd0);
      chk("midrst.err", 64'(err), 64'd0);
      chk("midrst.cpu_rst", 64'(cpu_rst), 64'd1);
      chk("midrst.cnt", 64'(byte_cnt), 64'd0);
      chk("midrst.nwrites", 64'(log_q.size()), 64'd2);
      rst = 1'b0;
      mem_m[0] = 8'h5A; mem_v[0] = 1'b1;
      mem_m[1] = 8'hC3; mem_v[1] = 1'b1;
      @(posedge clk); #1;
    end
    rand_frame(fr, 12, 1'b0);
    run_load("after_rst", fr, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
